// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR sequence generator: FSM encoding and mode constants.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR shift, Fibonacci or Galois form selected by mode.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] taps,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (mode == MODE_GAL) nxt = (cur >> 1) ^ (cur[0] ? taps : '0);
    else                  nxt = {cur[WIDTH-2:0], ^(cur & taps)};
  end

endmodule

// File: rtl/lfsr_seq_gen.sv
// LFSR sequence generator: runs a latched number of shifts from a seed and
// reports each new state, completion and error (zero taps or abort).
module lfsr_seq_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] taps,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] steps,
  input  logic             abort,
  output logic [WIDTH-1:0] num,
  output logic             num_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t           state;
  logic             mode_q;
  logic [WIDTH-1:0] taps_q;
  logic [WIDTH-1:0] seed_q;
  logic [CNT_W-1:0] steps_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [WIDTH-1:0] num_nxt;

  assign cnt_nxt = cnt + CNT_W'(1);

  lfsr_step #(.WIDTH(WIDTH)) u_step (
    .mode (mode_q),
    .taps (taps_q),
    .cur  (num),
    .nxt  (num_nxt)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      num       <= WIDTH'(1);
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      num_valid <= 1'b0;
      err       <= 1'b0;
      mode_q    <= MODE_FIB;
      taps_q    <= '0;
      seed_q    <= '0;
      steps_q   <= '0;
    end else begin
      done      <= 1'b0;
      num_valid <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          mode_q  <= mode;
          taps_q  <= taps;
          seed_q  <= seed;
          steps_q <= steps;
          err     <= 1'b0;
          busy    <= 1'b1;
          state   <= ST_LOAD;
        end
        ST_LOAD: if (abort) begin
          // abort leaves num untouched, even before the seed is applied
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          err   <= 1'b1;
        end else begin
          num <= (seed_q == '0) ? WIDTH'(1) : seed_q;
          cnt <= '0;
          err <= 1'b0;
          if (taps_q == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (steps_q == '0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: if (abort) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          err   <= 1'b1;
        end else begin
          num       <= num_nxt;
          cnt       <= cnt_nxt;
          num_valid <= 1'b1;
          // cnt < steps_q here, so cnt_nxt never wraps even at the max count
          if (cnt_nxt == steps_q) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// Directed bench for lfsr_seq_gen: an 8-bit instance for most cases and a
// 4-bit instance with a 4-bit counter for the full-period / max-steps case.
module tb_lfsr_seq_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start, mode, abort;
  logic [7:0] taps, seed, num;
  logic [15:0] steps;
  logic       nv, busy, done, err;

  logic       start4, mode4, abort4;
  logic [3:0] taps4, seed4, num4, steps4;
  logic       nv4, busy4, done4, err4;

  lfsr_seq_gen #(.WIDTH(8), .CNT_W(16)) dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start), .mode(mode), .taps(taps),
    .seed(seed), .steps(steps), .abort(abort), .num(num), .num_valid(nv),
    .busy(busy), .done(done), .err(err)
  );

  lfsr_seq_gen #(.WIDTH(4), .CNT_W(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start4), .mode(mode4), .taps(taps4),
    .seed(seed4), .steps(steps4), .abort(abort4), .num(num4), .num_valid(nv4),
    .busy(busy4), .done(done4), .err(err4)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] fib8 [0:9] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23,
                             8'h47, 8'h8E, 8'h1C, 8'h38, 8'h71};
  logic [3:0] seq4 [0:14] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5,
                              4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] seen;
    int          pulses;
    start = 0; mode = 0; abort = 0; taps = '0; seed = '0; steps = '0;
    start4 = 0; mode4 = 0; abort4 = 0; taps4 = '0; seed4 = '0; steps4 = '0;

    // reset state
    tick(); tick();
    chk("rst_num", num, 8'h01);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nv", nv, 0);
    chk("rst_err", err, 0);
    chk("rst_num4", num4, 4'h1);
    rst = 0;

    // Fibonacci, 4 steps
    mode = 0; taps = 8'hB8; seed = 8'h01; steps = 16'd4; start = 1;
    tick(); start = 0;
    chk("A_load_busy", busy, 1);
    chk("A_load_nv", nv, 0);
    tick();
    chk("A_run_num", num, 8'h01);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("A_nv", nv, 1);
      chk("A_num", num, fib8[i]);
      chk("A_done", done, (i == 3));
    end
    chk("A_err", err, 0);
    chk("A_busy", busy, 0);
    tick();
    chk("A_done_clr", done, 0);
    chk("A_nv_clr", nv, 0);
    taps = '0; seed = 8'hFF; steps = 16'd9;
    tick();
    chk("A_idle_hold", num, 8'h11);
    chk("A_idle_busy", busy, 0);

    // Galois, 2 steps
    mode = 1; taps = 8'hB8; seed = 8'h01; steps = 16'd2; start = 1;
    tick(); start = 0;
    tick();
    tick();
    chk("B_num0", num, 8'hB8);
    chk("B_nv0", nv, 1);
    chk("B_done0", done, 0);
    tick();
    chk("B_num1", num, 8'h5C);
    chk("B_done1", done, 1);
    tick();
    chk("B_done_clr", done, 0);
    chk("B_hold", num, 8'h5C);

    // 4-bit full period with steps at counter maximum
    mode4 = 0; taps4 = 4'hC; seed4 = 4'h1; steps4 = 4'hF; start4 = 1;
    tick(); start4 = 0;
    tick();
    seen = '0;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("C_nv", nv4, 1);
      chk("C_num", num4, seq4[i]);
      chk("C_done", done4, (i == 14));
      seen[num4] = 1'b1;
    end
    chk("C_distinct", $countones(seen), 15);
    chk("C_err", err4, 0);
    tick();
    chk("C_done_clr", done4, 0);

    // seed 0 lockup guard with zero steps
    mode = 0; taps = 8'hB8; seed = 8'h00; steps = 16'd0; start = 1;
    tick(); start = 0;
    chk("D_busy", busy, 1);
    tick();
    chk("D_done", done, 1);
    chk("D_num", num, 8'h01);
    chk("D_nv", nv, 0);
    chk("D_err", err, 0);
    tick();

    // zero tap mask
    taps = 8'h00; seed = 8'h05; steps = 16'd3; start = 1;
    tick(); start = 0;
    chk("D2_nv_load", nv, 0);
    tick();
    chk("D2_done", done, 1);
    chk("D2_err", err, 1);
    chk("D2_nv", nv, 0);
    tick();
    chk("D2_err_held", err, 1);
    chk("D2_done_clr", done, 0);
    chk("D2_num", num, 8'h05);

    // abort after 10 shifts, with an ignored start while busy
    mode = 0; taps = 8'hB8; seed = 8'h01; steps = 16'd100; start = 1;
    tick(); start = 0;
    chk("E_err_clr", err, 0);
    tick();
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin start = 1; seed = 8'hFF; mode = 1; end
      tick();
      start = 0;
      if (nv) pulses++;
      chk("E_num", num, fib8[i]);
    end
    chk("E_pulses", pulses, 10);
    abort = 1;
    tick(); abort = 0;
    chk("E_done", done, 1);
    chk("E_err", err, 1);
    chk("E_nv", nv, 0);
    chk("E_frozen", num, 8'h71);
    chk("E_busy", busy, 0);
    tick();
    chk("E_done_clr", done, 0);
    chk("E_err_held", err, 1);

    // reset mid-run beats start and abort
    mode = 0; taps = 8'hB8; seed = 8'h01; steps = 16'd100; start = 1;
    tick(); start = 0;
    tick(); tick(); tick();
    chk("F_pre_num", num, 8'h04);
    rst = 1; start = 1; abort = 1;
    tick();
    chk("F_num", num, 8'h01);
    chk("F_busy", busy, 0);
    chk("F_done", done, 0);
    chk("F_nv", nv, 0);
    chk("F_err", err, 0);
    rst = 0; start = 0; abort = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("F_no_done", done, 0);
      chk("F_idle", busy, 0);
      chk("F_hold", num, 8'h01);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
